// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding and the NOP word
// that the decoder sees between instructions.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_FETCH,
    FS_ISSUE,
    FS_HALT
  } fetch_state_t;

  localparam logic [15:0] NOP_INSTRUCTION = 16'h0000;

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// Program counter register: loads a jump target or increments,
// wrapping modulo 2^PC_WIDTH.
module program_counter #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                load_en,
  input  logic                inc_en,
  input  logic [PC_WIDTH-1:0] load_value,
  output logic [PC_WIDTH-1:0] pc
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= load_value;
    end else if (inc_en) begin
      pc <= pc + PC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: requests words from program memory and holds each one
// for the decoder until it is consumed (i_stall low on a clock edge).
//
// Handshakes: memory read completes on an edge where o_pm_req=1 and i_pm_ready=1;
// the presented word is consumed on an edge where o_instr_valid=1 and i_stall=0.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [PC_WIDTH-1:0] HALT_ADDR   = '1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_run,
  input  logic                   i_stall,
  input  logic                   i_jump_en,
  input  logic [PC_WIDTH-1:0]    i_jump_addr,
  output logic                   o_pm_req,
  output logic [PC_WIDTH-1:0]    o_pm_addr,
  input  logic                   i_pm_ready,
  input  logic [INSTR_WIDTH-1:0] i_pm_data,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic                   o_instr_valid,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic                   o_halted,
  output fetch_state_t           o_state
);

  fetch_state_t          state;
  logic [PC_WIDTH-1:0]   pc;
  logic                  consume;
  logic                  load_en;
  logic                  inc_en;

  // Jump is only honoured on the consume edge; a stalled ISSUE ignores it.
  assign consume = (state == FS_ISSUE) && !i_stall;
  assign load_en = consume && i_jump_en;
  assign inc_en  = consume && !i_jump_en;

  program_counter #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .load_en    (load_en),
    .inc_en     (inc_en),
    .load_value (i_jump_addr),
    .pc         (pc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= FS_IDLE;
      o_instruction <= INSTR_WIDTH'(NOP_INSTRUCTION);
      o_instr_valid <= 1'b0;
      o_pc          <= RESET_PC;
    end else begin
      case (state)
        FS_IDLE: begin
          if (i_run) state <= FS_FETCH;
        end
        FS_FETCH: begin
          // i_run is not looked at here: an issued request always completes.
          if (i_pm_ready) begin
            o_instruction <= i_pm_data;
            o_pc          <= pc;
            o_instr_valid <= 1'b1;
            state         <= FS_ISSUE;
          end
        end
        FS_ISSUE: begin
          if (!i_stall) begin
            o_instr_valid <= 1'b0;
            o_instruction <= INSTR_WIDTH'(NOP_INSTRUCTION);
            if (o_pc == HALT_ADDR) state <= FS_HALT;
            else if (i_run)        state <= FS_FETCH;
            else                   state <= FS_IDLE;
          end
        end
        FS_HALT: begin
          state <= FS_HALT;
        end
        default: begin
          state <= FS_IDLE;
        end
      endcase
    end
  end

  assign o_pm_req  = (state == FS_FETCH);
  assign o_pm_addr = pc;
  assign o_halted  = (state == FS_HALT);
  assign o_state   = state;

endmodule
